// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter of the RV32I core.
package rv32_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive fetch losses; force_if hands the next
// arbitration to fetch once the count reaches STARVE_MAX.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lose,
  input  logic clr,
  output logic force_if
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over a loss, and the count saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (lose && (cnt_q != CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks on the arbiter's grant and completion outputs.
module mem_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic idle,
  input logic if_gnt,
  input logic d_gnt,
  input logic if_rvalid,
  input logic d_rvalid
);

  // Grants are exclusive and only given while idle; completions never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(if_gnt && d_gnt));
      assert (!((if_gnt || d_gnt) && !idle));
      assert (!(if_rvalid && d_rvalid));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store,
// one access in flight at a time, data first with a fetch starvation guard.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int          CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              st_q, st_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic idle_s;
  logic force_if_s;
  logic if_win_s;
  logic d_win_s;
  logic lose_s;
  logic clr_s;

  // Arbitration is only open in IDLE and never while reset is asserted.
  assign idle_s   = (state_q == IDLE) && !rst;
  assign if_win_s = idle_s && if_req && (!d_req || force_if_s);
  assign d_win_s  = idle_s && d_req && !if_win_s;
  assign lose_s   = d_win_s && if_req;
  assign clr_s    = idle_s && (if_win_s || !if_req);

  assign if_gnt = if_win_s;
  assign d_gnt  = d_win_s;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .lose     (lose_s),
    .clr      (clr_s),
    .force_if (force_if_s)
  );

  // Next state, captured request fields and response routing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    st_d        = st_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_win_s) begin
          owner_d     = OWN_D;
          st_d        = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          state_d     = ISSUE;
        end else if (if_win_s) begin
          owner_d     = OWN_IF;
          st_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          state_d     = ISSUE;
        end else begin
          state_d     = IDLE;
        end
      end
      ISSUE: begin
        lat_d = LAT_LOAD;
        if (MEM_LAT == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The transition into RESP is the step where the count reaches zero.
        if (lat_q <= CNT_W'(1)) begin
          lat_d   = '0;
          state_d = RESP;
        end else begin
          lat_d   = lat_q - CNT_W'(1);
        end
      end
      RESP: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
        if (owner_q == OWN_IF) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else if (owner_q == OWN_D) begin
          d_rvalid_d  = 1'b1;
          d_rdata_d   = st_q ? '0 : mem_rdata;
        end else begin
          if_rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      lat_q       <= '0;
      st_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      st_q        <= st_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

  mem_port_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .idle      (idle_s),
    .if_gnt    (if_gnt),
    .d_gnt     (d_gnt),
    .if_rvalid (if_rvalid),
    .d_rvalid  (d_rvalid)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected events with their cycle
// numbers; monitors on the falling edge pop and compare as the DUTs emit them.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // MEM_LAT = 2 instance
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // MEM_LAT = 1 instance
  logic        if_req1, if_gnt1, if_rvalid1;
  logic [31:0] if_addr1, if_rdata1;
  logic        d_gnt1, d_rvalid1;
  logic [31:0] d_rdata1;
  logic        mem_en1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;

  ev_t q_gif[$], q_gd[$], q_mem[$], q_rvif[$], q_rvd[$];
  ev_t q1_gif[$], q1_mem[$], q1_rvif[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_be(mem_be1), .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmem(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], 16'hA5A5};
  endfunction

  // Memory models: data is valid exactly MEM_LAT cycles after mem_en, garbage otherwise.
  logic        pv1 = 1'b0, pv2 = 1'b0, qv1 = 1'b0;
  logic [31:0] pa1 = 32'h0, pa2 = 32'h0, qa1 = 32'h0;
  always @(posedge clk) begin
    pv1 <= mem_en;  pa1 <= mem_addr;
    pv2 <= pv1;     pa2 <= pa1;
    qv1 <= mem_en1; qa1 <= mem_addr1;
  end
  assign mem_rdata  = pv2 ? fmem(pa2) : 32'hBAD0BAD0;
  assign mem_rdata1 = qv1 ? fmem(qa1) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic ev_t mk(input int c, input logic [31:0] a, input logic w,
                             input logic [3:0] b, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.addr = a; e.we = w; e.be = b; e.data = d;
    return e;
  endfunction

  // Monitor for the MEM_LAT = 2 instance.
  always @(negedge clk) begin
    ev_t e;
    if (if_gnt === 1'b1) begin
      if (q_gif.size() == 0) unexpected("if_gnt");
      else begin e = q_gif.pop_front(); chk("if_gnt cycle", cyc, e.cyc); end
    end
    if (d_gnt === 1'b1) begin
      if (q_gd.size() == 0) unexpected("d_gnt");
      else begin e = q_gd.pop_front(); chk("d_gnt cycle", cyc, e.cyc); end
    end
    if (mem_en === 1'b1) begin
      if (q_mem.size() == 0) unexpected("mem_en");
      else begin
        e = q_mem.pop_front();
        chk("mem_en cycle", cyc, e.cyc);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        chk("mem_be", {28'h0, mem_be}, {28'h0, e.be});
        if (e.we) chk("mem_wdata", mem_wdata, e.data);
      end
    end
    if (if_rvalid === 1'b1) begin
      if (q_rvif.size() == 0) unexpected("if_rvalid");
      else begin
        e = q_rvif.pop_front();
        chk("if_rvalid cycle", cyc, e.cyc);
        chk("if_rdata", if_rdata, e.data);
      end
    end
    if (d_rvalid === 1'b1) begin
      if (q_rvd.size() == 0) unexpected("d_rvalid");
      else begin
        e = q_rvd.pop_front();
        chk("d_rvalid cycle", cyc, e.cyc);
        chk("d_rdata", d_rdata, e.data);
      end
    end
  end

  // Monitor for the MEM_LAT = 1 instance.
  always @(negedge clk) begin
    ev_t e;
    if (if_gnt1 === 1'b1) begin
      if (q1_gif.size() == 0) unexpected("lat1 if_gnt");
      else begin e = q1_gif.pop_front(); chk("lat1 if_gnt cycle", cyc, e.cyc); end
    end
    if (mem_en1 === 1'b1) begin
      if (q1_mem.size() == 0) unexpected("lat1 mem_en");
      else begin
        e = q1_mem.pop_front();
        chk("lat1 mem_en cycle", cyc, e.cyc);
        chk("lat1 mem_addr", mem_addr1, e.addr);
      end
    end
    if (if_rvalid1 === 1'b1) begin
      if (q1_rvif.size() == 0) unexpected("lat1 if_rvalid");
      else begin
        e = q1_rvif.pop_front();
        chk("lat1 if_rvalid cycle", cyc, e.cyc);
        chk("lat1 if_rdata", if_rdata1, e.data);
      end
    end
    if ((d_gnt1 === 1'b1) || (d_rvalid1 === 1'b1)) unexpected("lat1 data port");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " mem_en"}, {31'h0, mem_en}, 32'h0);
    chk({tag, " mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " mem_be"}, {28'h0, mem_be}, 32'h0);
    chk({tag, " if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
    chk({tag, " if_rdata"}, if_rdata, 32'h0);
    chk({tag, " d_rvalid"}, {31'h0, d_rvalid}, 32'h0);
    chk({tag, " d_rdata"}, d_rdata, 32'h0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    if_req1 = 1'b0; if_addr1 = 32'h0;

    // Reset: requests present, but grants held low and outputs cleared.
    tick(2);
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("reset if_gnt", {31'h0, if_gnt}, 32'h0);
    chk("reset d_gnt", {31'h0, d_gnt}, 32'h0);
    chk_outputs_zero("reset");
    tick(1);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick(2);

    // Fetch only.
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    q_gif.push_back(mk(t0, 32'h0, 1'b0, 4'h0, 32'h0));
    q_mem.push_back(mk(t0 + 1, 32'h100, 1'b0, 4'h0, 32'h0));
    q_rvif.push_back(mk(t0 + 4, 32'h0, 1'b0, 4'h0, 32'hDEADBEEF));
    tick(1); if_req = 1'b0;
    tick(5);

    // Collision: store wins, held fetch is granted as the store completes.
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; d_be = 4'hF;
    q_gd.push_back(mk(t0, 32'h0, 1'b0, 4'h0, 32'h0));
    q_mem.push_back(mk(t0 + 1, 32'h20, 1'b1, 4'hF, 32'h55));
    q_rvd.push_back(mk(t0 + 4, 32'h0, 1'b0, 4'h0, 32'h0));
    q_gif.push_back(mk(t0 + 4, 32'h0, 1'b0, 4'h0, 32'h0));
    q_mem.push_back(mk(t0 + 5, 32'h200, 1'b0, 4'h0, 32'h0));
    q_rvif.push_back(mk(t0 + 8, 32'h0, 1'b0, 4'h0, 32'h0200A5A5));
    tick(1); d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    tick(4); if_req = 1'b0;
    tick(5);

    // Starvation: data wins four times, fetch the fifth, then data again.
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        q_gif.push_back(mk(t0 + 4 * k, 32'h0, 1'b0, 4'h0, 32'h0));
        q_mem.push_back(mk(t0 + 4 * k + 1, 32'h300, 1'b0, 4'h0, 32'h0));
        q_rvif.push_back(mk(t0 + 4 * k + 4, 32'h0, 1'b0, 4'h0, 32'h0300A5A5));
      end else begin
        q_gd.push_back(mk(t0 + 4 * k, 32'h0, 1'b0, 4'h0, 32'h0));
        q_mem.push_back(mk(t0 + 4 * k + 1, 32'h40, 1'b0, 4'h0, 32'h0));
        q_rvd.push_back(mk(t0 + 4 * k + 4, 32'h0, 1'b0, 4'h0, 32'h0040A5A5));
      end
    end
    tick(21); if_req = 1'b0; d_req = 1'b0;
    tick(5);

    // Back-to-back loads at 0x0, 0x4, 0x8.
    t0 = cyc;
    d_req = 1'b1; d_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      q_gd.push_back(mk(t0 + 4 * k, 32'h0, 1'b0, 4'h0, 32'h0));
      q_mem.push_back(mk(t0 + 4 * k + 1, 32'(4 * k), 1'b0, 4'h0, 32'h0));
      q_rvd.push_back(mk(t0 + 4 * k + 4, 32'h0, 1'b0, 4'h0, {16'(4 * k), 16'hA5A5}));
    end
    tick(1); d_addr = 32'h4;
    tick(4); d_addr = 32'h8;
    tick(4); d_req = 1'b0;
    tick(4);

    // Reset during WAIT: access abandoned, then a fresh load proceeds normally.
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h400;
    q_gif.push_back(mk(t0, 32'h0, 1'b0, 4'h0, 32'h0));
    q_mem.push_back(mk(t0 + 1, 32'h400, 1'b0, 4'h0, 32'h0));
    tick(1); if_req = 1'b0;
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("mid reset");
    tick(1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    q_gd.push_back(mk(t0 + 4, 32'h0, 1'b0, 4'h0, 32'h0));
    q_mem.push_back(mk(t0 + 5, 32'h44, 1'b0, 4'h0, 32'h0));
    q_rvd.push_back(mk(t0 + 8, 32'h0, 1'b0, 4'h0, 32'h0044A5A5));
    tick(1); d_req = 1'b0;
    // A request raised and withdrawn while busy must never be granted.
    tick(1); if_req = 1'b1;
    tick(1); if_req = 1'b0;
    tick(3);

    // MEM_LAT = 1: ISSUE goes straight to RESP.
    t0 = cyc;
    if_req1 = 1'b1; if_addr1 = 32'h104;
    q1_gif.push_back(mk(t0, 32'h0, 1'b0, 4'h0, 32'h0));
    q1_mem.push_back(mk(t0 + 1, 32'h104, 1'b0, 4'h0, 32'h0));
    q1_rvif.push_back(mk(t0 + 3, 32'h0, 1'b0, 4'h0, 32'h0104A5A5));
    tick(1); if_req1 = 1'b0;
    tick(5);

    chk("pending if_gnt", q_gif.size(), 32'h0);
    chk("pending d_gnt", q_gd.size(), 32'h0);
    chk("pending mem_en", q_mem.size(), 32'h0);
    chk("pending if_rvalid", q_rvif.size(), 32'h0);
    chk("pending d_rvalid", q_rvd.size(), 32'h0);
    chk("pending lat1 events", q1_gif.size() + q1_mem.size() + q1_rvif.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory (fixed read latency) between the instruction-fetch path and the load/store path of the RV32I core.
- Sits between PC/fetch logic and load/store logic on one side and the memory macro on the other.
- Decides a winner each idle cycle, issues exactly one access at a time, and routes each completion back to its owner.
- Data accesses have priority; a starvation guard guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range is MEM_LAT >= 1.
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next arbitration.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address; stable while if_req=1.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid / store complete, one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for store completions.
- mem_en  out  1  memory access strobe, one-cycle pulse.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset: while rst=1 at a clock edge, all registered outputs go to 0, the FSM goes to IDLE, the owner tag becomes NONE, and starve_cnt becomes 0.
  - An in-flight access is abandoned; its mem_rdata is ignored and no rvalid is produced.
  - The grant outputs are combinational and held at 0 while rst=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration is combinational in the same cycle T:
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both requesting: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Winner's gnt = 1 in cycle T. Request fields are captured at the end of T and the FSM moves to ISSUE.
  - No request: stay in IDLE, gnt = 0.
- ISSUE (cycle T+1):
  - mem_en = 1; mem_we/addr/wdata/be driven from the captured fields.
  - mem_we = 0 and mem_be = 0 for fetches.
  - Load latency counter with MEM_LAT-1 and go to WAIT; go directly to RESP when MEM_LAT = 1.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP (cycle T+1+MEM_LAT):
  - Register mem_rdata into the owner's rdata (0 for stores).
  - The owner's rvalid pulses in cycle T+2+MEM_LAT.
  - The FSM returns to IDLE in that same cycle, so a new grant is possible then.
  - Throughput: one access per MEM_LAT+2 cycles.
- Registered output timing: rvalid is 0 in every other cycle. rdata holds its last value between pulses.
- gnt timing: gnt is never asserted outside IDLE. A requester seeing req=1 and gnt=0 keeps its request held.
- Request withdrawal: req may drop before gnt without effect. If req is still high in the cycle after gnt, it is a new request.
- Starvation counter (starve_cnt, saturating at STARVE_MAX):
  - Increments on each IDLE arbitration where if_req=1 and data wins.
  - Clears on a fetch grant or when if_req = 0 in an IDLE cycle.
- Simultaneous events: an rvalid pulse and a new gnt in the same cycle are legal and expected.
- Only one outstanding access exists at any time. The owner tag is never overwritten before RESP.

Decomposition:
- Package rv32_mem_pkg:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_D}.
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - ADDR_W / DATA_W defaults.
  - Byte-enable width constant BE_W = 4.
- One sub-module, arb_starve_ctr: the saturating starvation counter. Inputs: lose, clr. Output: force_if.

Test Plan:
- Fetch only, MEM_LAT=2: if_req=1, if_addr=0x100 at T.
  - Required: if_gnt at T; mem_en/mem_addr=0x100 at T+1.
  - mem_rdata=0xDEADBEEF at T+3 gives if_rvalid, if_rdata=0xDEADBEEF at T+4.
- Collision: if_req=d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55, d_be=0xF at T.
  - Required: d_gnt only; mem_we=1 at T+1; d_rvalid with d_rdata=0 at T+4.
  - if_gnt in cycle T+4.
- Starvation: if_req held high, with d_req high at every IDLE cycle.
  - Required: data wins 4 times, fetch wins the 5th arbitration, then the counter restarts.
- Back-to-back loads: d_req at every IDLE, addresses 0x0, 0x4, 0x8.
  - Required: mem_en at T+1, T+5, T+9; exactly one outstanding access.
- Reset mid-operation: rst=1 for one cycle during WAIT.
  - Required: no rvalid for that access; all outputs 0; a new request after reset is granted normally.
- Latency corner: MEM_LAT=1 with a fetch at T.
  - Required: if_rvalid at T+3; the ISSUE to RESP path skips WAIT.
